// File: rtl/de1_soc_qsys_trace_system_0_link_link_t2h_timing_if.sv
// Avalon-ST handshake bundle for the t2h timing adapter.
// Sink side (in_*) is ready-latency 0; source side (out_*) is ready-latency L.
interface de1_soc_qsys_trace_system_0_link_link_t2h_timing_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/de1_soc_qsys_trace_system_0_link_link_t2h_timing.sv
// Avalon-ST timing adapter, target-to-host leg of the trace link.
// Ready-latency-0 sink feeds a ready-latency-L source through a small FIFO.
module de1_soc_qsys_trace_system_0_link_link_t2h_timing #(
   parameter int DATA_W            = 8,
   parameter int OUT_READY_LATENCY = 1,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   de1_soc_qsys_trace_system_0_link_link_t2h_timing_if.slave bus,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int L  = OUT_READY_LATENCY;
   localparam int RW = (L == 0) ? 1 : L;
   localparam logic [AW:0] OCC_FULL = (AW + 1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       occ_q, occ_d;
   logic [RW-1:0]     rdy_q, rdy_d;
   logic              eff_ready;
   logic              push;
   logic              pop;

   // With L=0 the host ready is used directly and rdy_q is dead.
   always_comb begin
      if (L == 0) eff_ready = bus.out_ready;
      else        eff_ready = rdy_q[RW-1];
   end

   assign bus.in_ready  = (occ_q != OCC_FULL) && !reset;
   assign bus.out_valid = eff_ready && (occ_q != '0) && !reset;
   assign bus.out_data  = mem_q[rptr_q];
   assign fill_level    = occ_q;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      rdy_d[0] = bus.out_ready;
      for (int i = 1; i < RW; i++) begin
         rdy_d[i] = rdy_q[i-1];
      end
      if (push) begin
         mem_d[wptr_q] = bus.in_data;
         wptr_d        = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (pop && !push) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
         rdy_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
         rdy_q  <= rdy_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push && occ_q == OCC_FULL));
         assert (!(pop && occ_q == '0));
      end
   end
endmodule

// File: tb/tb_de1_soc_qsys_trace_system_0_link_link_t2h_timing.sv
// Bench for the t2h timing adapter: vector table plus model-checked
// streaming, wrap, and random traffic on L=1, L=0 and L=3 builds.
module tb_de1_soc_qsys_trace_system_0_link_link_t2h_timing;
   localparam int D = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, rst0, rst3;
   logic [2:0] fl1, fl0, fl3;

   de1_soc_qsys_trace_system_0_link_link_t2h_timing_if #(.DATA_W(8)) b1 ();
   de1_soc_qsys_trace_system_0_link_link_t2h_timing_if #(.DATA_W(8)) b0 ();
   de1_soc_qsys_trace_system_0_link_link_t2h_timing_if #(.DATA_W(8)) b3 ();

   de1_soc_qsys_trace_system_0_link_link_t2h_timing #(
      .DATA_W(8), .OUT_READY_LATENCY(1), .FIFO_DEPTH(D)
   ) u1 (.clk(clk), .reset(rst1), .bus(b1), .fill_level(fl1));

   de1_soc_qsys_trace_system_0_link_link_t2h_timing #(
      .DATA_W(8), .OUT_READY_LATENCY(0), .FIFO_DEPTH(D)
   ) u0 (.clk(clk), .reset(rst0), .bus(b0), .fill_level(fl0));

   de1_soc_qsys_trace_system_0_link_link_t2h_timing #(
      .DATA_W(8), .OUT_READY_LATENCY(3), .FIFO_DEPTH(D)
   ) u3 (.clk(clk), .reset(rst3), .bus(b3), .fill_level(fl3));

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       eir;
      logic       eov;
      logic [7:0] ed;
      logic [2:0] efl;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state, one slot per DUT instance.
   logic [7:0] mq [3][8];
   int         mh [3];
   int         mc [3];
   logic [7:0] hist [3];

   function automatic vec_t v(int rs, int iv, int d, int o,
                              int eir, int eov, int ed, int ef);
      vec_t r;
      r.rst  = rs[0];
      r.iv   = iv[0];
      r.d    = d[7:0];
      r.ordy = o[0];
      r.eir  = eir[0];
      r.eov  = eov[0];
      r.ed   = ed[7:0];
      r.efl  = ef[2:0];
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model(int i, int lat, logic rst, logic iv,
                        logic [7:0] din, logic ordy, logic ir,
                        logic ov, logic [7:0] od, logic [2:0] fl,
                        output logic pushed);
      logic eff, eir, eov;
      eff = (lat == 0) ? ordy : hist[i][lat-1];
      eir = !rst && (mc[i] != D);
      eov = !rst && eff && (mc[i] != 0);
      chk($sformatf("u%0d in_ready", i), ir, eir);
      chk($sformatf("u%0d out_valid", i), ov, eov);
      chk($sformatf("u%0d fill_level", i), fl, mc[i]);
      if (eov) chk($sformatf("u%0d out_data", i), od, mq[i][mh[i]]);
      pushed = iv && eir;
      if (rst) begin
         mh[i]   = 0;
         mc[i]   = 0;
         hist[i] = '0;
      end else begin
         if (pushed) mq[i][(mh[i] + mc[i]) % 8] = din;
         if (eov) begin
            mh[i] = (mh[i] + 1) % 8;
            mc[i]--;
         end
         if (pushed) mc[i]++;
         hist[i] = {hist[i][6:0], ordy};
      end
   endtask

   task automatic cyc1(input logic rst, input logic iv,
                       input logic [7:0] d, input logic ordy,
                       output logic ir, output logic ov,
                       output logic [7:0] od, output logic [2:0] fl);
      rst1 = rst;
      b1.in_valid  = iv;
      b1.in_data   = d;
      b1.out_ready = ordy;
      @(negedge clk);
      ir = b1.in_ready;
      ov = b1.out_valid;
      od = b1.out_data;
      fl = fl1;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc03(input logic rst, input logic iv,
                        input logic [7:0] d0, input logic [7:0] d3,
                        input logic ordy,
                        output logic ir0, output logic ov0,
                        output logic [7:0] od0, output logic [2:0] f0,
                        output logic ir3, output logic ov3,
                        output logic [7:0] od3, output logic [2:0] f3);
      rst0 = rst;
      rst3 = rst;
      b0.in_valid  = iv;
      b0.in_data   = d0;
      b0.out_ready = ordy;
      b3.in_valid  = iv;
      b3.in_data   = d3;
      b3.out_ready = ordy;
      @(negedge clk);
      ir0 = b0.in_ready;
      ov0 = b0.out_valid;
      od0 = b0.out_data;
      f0  = fl0;
      ir3 = b3.in_ready;
      ov3 = b3.out_valid;
      od3 = b3.out_data;
      f3  = fl3;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t       tv [23];
      logic       ir, ov, pu, ir3, ov3, pu3, iv, ordy;
      logic [7:0] od, od3, d, nx0, nx3;
      logic [2:0] fl, f3;
      int         pops;

      for (int i = 0; i < 3; i++) begin
         mh[i]   = 0;
         mc[i]   = 0;
         hist[i] = '0;
      end

      // rst, iv, din, out_ready | in_ready, out_valid, out_data, fill
      tv[0]  = v(1, 0, 'h00, 0,  0, 0, 'h00, 0);
      tv[1]  = v(0, 1, 'hA0, 0,  1, 0, 'h00, 0);
      tv[2]  = v(0, 1, 'hA1, 0,  1, 0, 'h00, 1);
      tv[3]  = v(0, 1, 'hA2, 0,  1, 0, 'h00, 2);
      tv[4]  = v(0, 1, 'hA3, 0,  1, 0, 'h00, 3);
      tv[5]  = v(0, 1, 'hA4, 0,  0, 0, 'h00, 4);
      tv[6]  = v(0, 1, 'hA4, 1,  0, 0, 'h00, 4);
      tv[7]  = v(0, 1, 'hA4, 1,  0, 1, 'hA0, 4);
      tv[8]  = v(0, 1, 'hA4, 1,  1, 1, 'hA1, 3);
      tv[9]  = v(0, 0, 'h00, 0,  1, 1, 'hA2, 3);
      tv[10] = v(0, 0, 'h00, 1,  1, 0, 'h00, 2);
      tv[11] = v(0, 0, 'h00, 0,  1, 1, 'hA3, 2);
      tv[12] = v(0, 0, 'h00, 1,  1, 0, 'h00, 1);
      tv[13] = v(0, 0, 'h00, 0,  1, 1, 'hA4, 1);
      tv[14] = v(0, 0, 'h00, 1,  1, 0, 'h00, 0);
      tv[15] = v(0, 0, 'h00, 1,  1, 0, 'h00, 0);
      tv[16] = v(0, 1, 'hB0, 0,  1, 0, 'h00, 0);
      tv[17] = v(0, 1, 'hB1, 0,  1, 0, 'h00, 1);
      tv[18] = v(0, 1, 'hB2, 1,  1, 0, 'h00, 2);
      tv[19] = v(1, 0, 'h00, 1,  0, 0, 'h00, 3);
      tv[20] = v(0, 1, 'h5A, 1,  1, 0, 'h00, 0);
      tv[21] = v(0, 0, 'h00, 1,  1, 1, 'h5A, 1);
      tv[22] = v(0, 0, 'h00, 1,  1, 0, 'h00, 0);

      rst1 = 1'b1;
      rst0 = 1'b1;
      rst3 = 1'b1;
      b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
      b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
      b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
      @(posedge clk);
      #1;

      // Backpressure to full, ready toggling, reset mid-stream.
      for (int k = 0; k < 23; k++) begin
         cyc1(tv[k].rst, tv[k].iv, tv[k].d, tv[k].ordy, ir, ov, od, fl);
         chk($sformatf("vec%0d in_ready", k), ir, tv[k].eir);
         chk($sformatf("vec%0d out_valid", k), ov, tv[k].eov);
         chk($sformatf("vec%0d fill_level", k), fl, tv[k].efl);
         if (tv[k].eov) chk($sformatf("vec%0d out_data", k), od, tv[k].ed);
      end

      // Streaming 0x00..0xFF with out_ready held high.
      cyc1(1'b1, 1'b0, 8'h00, 1'b1, ir, ov, od, fl);
      model(0, 1, 1'b1, 1'b0, 8'h00, 1'b1, ir, ov, od, fl, pu);
      pops = 0;
      for (int k = 0; k < 258; k++) begin
         iv = (k < 256);
         d  = k[7:0];
         cyc1(1'b0, iv, d, 1'b1, ir, ov, od, fl);
         model(0, 1, 1'b0, iv, d, 1'b1, ir, ov, od, fl, pu);
         chk("stream in_ready high", ir, 1'b1);
         chk("stream fill<=1", (fl <= 3'd1), 1'b1);
         if (ov) pops++;
      end
      chk("stream pop count", pops, 256);

      // Occupancy held at 2 with push and pop every cycle.
      cyc1(1'b1, 1'b0, 8'h00, 1'b0, ir, ov, od, fl);
      model(0, 1, 1'b1, 1'b0, 8'h00, 1'b0, ir, ov, od, fl, pu);
      pops = 0;
      for (int k = 0; k < 26; k++) begin
         iv   = (k < 22);
         ordy = (k != 0);
         d    = 8'h10 + k[7:0];
         cyc1(1'b0, iv, d, ordy, ir, ov, od, fl);
         model(0, 1, 1'b0, iv, d, ordy, ir, ov, od, fl, pu);
         if (k >= 2 && k < 22) chk("wrap fill==2", fl, 3'd2);
         if (ov) pops++;
      end
      chk("wrap pop count", pops, 22);

      // Random traffic on the L=0 and L=3 builds.
      rst1 = 1'b1;
      b1.in_valid = 1'b0;
      nx0 = 8'h00;
      nx3 = 8'h00;
      cyc03(1'b1, 1'b0, nx0, nx3, 1'b0, ir, ov, od, fl, ir3, ov3, od3, f3);
      model(1, 0, 1'b1, 1'b0, nx0, 1'b0, ir, ov, od, fl, pu);
      model(2, 3, 1'b1, 1'b0, nx3, 1'b0, ir3, ov3, od3, f3, pu3);
      for (int k = 0; k < 410; k++) begin
         if (k < 400) begin
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 9) >= 3);
         end else begin
            iv   = 1'b0;
            ordy = 1'b1;
         end
         cyc03(1'b0, iv, nx0, nx3, ordy, ir, ov, od, fl, ir3, ov3, od3, f3);
         if (ov3) chk("u2 ready 3 cycles earlier", hist[2][2], 1'b1);
         model(1, 0, 1'b0, iv, nx0, ordy, ir, ov, od, fl, pu);
         model(2, 3, 1'b0, iv, nx3, ordy, ir3, ov3, od3, f3, pu3);
         if (pu) nx0 = nx0 + 8'd1;
         if (pu3) nx3 = nx3 + 8'd1;
      end
      chk("u1 drained", fl0, 3'd0);
      chk("u2 drained", f3, 3'd0);
      chk("u2 symbols moved", (nx3 > 8'd20), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
